// File: rtl/piece_dropper.sv
// piece_dropper: move-execution stage ahead of victory_checker.
// A drop request is checked for legality. The requested column is then scanned
// upward from row 0 until an empty cell is found, and the player's piece is
// written into that cell. Next the stage starts victory_checker and waits for
// its verdict. Game-level results (winner, draw, game_over) stay latched until
// reset.
//
// Handshake: drop_req is a single-cycle request. It is accepted only while
// busy is low (IDLE). Every accepted request produces exactly one response
// pulse: drop_done or drop_invalid. check_start is a one-cycle pulse. The
// done_checking level is trusted only from the second cycle after that pulse,
// because the checker clears its previous done level one cycle late.
module piece_dropper #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drop_req,
    input  logic [2:0] drop_col,
    input  logic [1:0] player,
    output logic [2:0] row_read,
    output logic [2:0] col_read,
    input  logic [1:0] data_in,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       check_start,
    output logic [2:0] move_row,
    output logic [2:0] move_col,
    input  logic       done_checking,
    input  logic [1:0] winner_in,
    output logic       busy,
    output logic       drop_done,
    output logic       drop_invalid,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WRITE = 3'd2,
        START = 3'd3,
        ARM   = 3'd4,
        WAIT  = 3'd5,
        REJ   = 3'd6
    } state_t;

    localparam logic [3:0] COLS_W   = 4'(COLS);
    localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
    localparam logic [6:0] CELLS    = 7'(ROWS * COLS);

    state_t     state;
    logic [2:0] scan_row;
    logic [2:0] col_q;
    logic [1:0] player_q;
    logic [6:0] move_cnt;

    // The board is read only while scanning; the address is parked at 0 otherwise.
    assign row_read = (state == SCAN) ? scan_row : 3'd0;
    assign col_read = (state == SCAN) ? col_q    : 3'd0;

    // Main controller: state, registered strobes, move bookkeeping and latched game result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            scan_row     <= 3'd0;
            col_q        <= 3'd0;
            player_q     <= 2'b00;
            move_cnt     <= 7'd0;
            wr_en        <= 1'b0;
            wr_row       <= 3'd0;
            wr_col       <= 3'd0;
            wr_data      <= 2'b00;
            check_start  <= 1'b0;
            move_row     <= 3'd0;
            move_col     <= 3'd0;
            busy         <= 1'b0;
            drop_done    <= 1'b0;
            drop_invalid <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'b00;
            draw         <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            check_start  <= 1'b0;
            drop_done    <= 1'b0;
            drop_invalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (drop_req) begin
                        col_q    <= drop_col;
                        player_q <= player;
                        scan_row <= 3'd0;
                        busy     <= 1'b1;
                        if (game_over || ({1'b0, drop_col} >= COLS_W) ||
                            (player == 2'b00) || (player == 2'b11)) begin
                            state        <= REJ;
                            drop_invalid <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (data_in == 2'b00) begin
                        // The write strobe and move coordinates become visible in WRITE.
                        state    <= WRITE;
                        wr_en    <= 1'b1;
                        wr_row   <= scan_row;
                        wr_col   <= col_q;
                        wr_data  <= player_q;
                        move_row <= scan_row;
                        move_col <= col_q;
                        if (move_cnt != CELLS) begin
                            move_cnt <= move_cnt + 7'd1;
                        end
                    end else if (scan_row == ROW_LAST) begin
                        state        <= REJ;
                        drop_invalid <= 1'b1;
                    end else begin
                        scan_row <= scan_row + 3'd1;
                    end
                end
                WRITE: begin
                    state       <= START;
                    check_start <= 1'b1;
                end
                START: begin
                    state <= ARM;
                end
                ARM: begin
                    // done_checking still shows the previous check here; skip it.
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_checking) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        drop_done <= 1'b1;
                        // When a win and a full board coincide, the win takes precedence.
                        if (winner_in != 2'b00) begin
                            winner    <= winner_in;
                            game_over <= 1'b1;
                        end else if (move_cnt == CELLS) begin
                            draw      <= 1'b1;
                            game_over <= 1'b1;
                        end
                    end
                end
                REJ: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_dropper.sv
// Bench for piece_dropper. It provides a board memory, a victory_checker stand-in
// and a scoreboard that records the expected write, start and result events.
module tb_piece_dropper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       drop_req = 1'b0;
    logic [2:0] drop_col = 3'd0;
    logic [1:0] player = 2'b00;
    logic [2:0] row_read, col_read;
    logic [1:0] data_in;
    logic       wr_en;
    logic [2:0] wr_row, wr_col;
    logic [1:0] wr_data;
    logic       check_start;
    logic [2:0] move_row, move_col;
    logic       done_checking;
    logic [1:0] winner_in = 2'b00;
    logic       busy, drop_done, drop_invalid, game_over, draw;
    logic [1:0] winner;

    piece_dropper #(.ROWS(6), .COLS(7)) dut (
        .clk(clk), .rst_n(rst_n), .drop_req(drop_req), .drop_col(drop_col),
        .player(player), .row_read(row_read), .col_read(col_read), .data_in(data_in),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .check_start(check_start), .move_row(move_row), .move_col(move_col),
        .done_checking(done_checking), .winner_in(winner_in), .busy(busy),
        .drop_done(drop_done), .drop_invalid(drop_invalid), .game_over(game_over),
        .winner(winner), .draw(draw)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- board memory ----------------
    logic [1:0] board [8][8];
    assign data_in = board[row_read][col_read];
    always @(posedge clk) if (wr_en) board[wr_row][wr_col] <= wr_data;

    // ---------------- checker stand-in ----------------
    // It clears done one cycle after the start pulse, then raises it again 3 cycles later.
    logic       done_q;
    logic [2:0] ck_cnt;
    assign done_checking = done_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            ck_cnt <= 3'd0;
        end else if (check_start) begin
            ck_cnt <= 3'd1;
        end else if (ck_cnt != 3'd0) begin
            ck_cnt <= ck_cnt + 3'd1;
            if (ck_cnt == 3'd1) done_q <= 1'b0;
            if (ck_cnt == 3'd4) begin
                done_q <= 1'b1;
                ck_cnt <= 3'd0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [23:0] exp_wr_q[$];     // {cycle, row, col, data}
    logic [15:0] exp_start_q[$];  // cycle
    logic [27:0] exp_res_q[$];    // {cycle, kind, move_row, move_col, game_over, winner, draw}
    int busy_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every observed DUT event against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cyc++;
            if (wr_en) begin
                if (exp_wr_q.size() == 0) check("unexpected_wr_en", 32'd1, 32'd0);
                else check("write", {8'd0, 16'(cyc), wr_row, wr_col, wr_data}, {8'd0, exp_wr_q.pop_front()});
            end
            if (check_start) begin
                if (exp_start_q.size() == 0) check("unexpected_check_start", 32'd1, 32'd0);
                else check("check_start_cycle", {16'd0, 16'(cyc)}, {16'd0, exp_start_q.pop_front()});
            end
            if (drop_done || drop_invalid) begin
                if (exp_res_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                else check("result", {4'd0, 16'(cyc), drop_invalid, drop_done, move_row, move_col,
                                      game_over, winner, draw}, {4'd0, exp_res_q.pop_front()});
            end
        end
    end

    // ---------------- reference model state ----------------
    int         heights [7];
    int         m_cnt;
    logic [2:0] m_row, m_col;
    logic       m_over, m_draw;
    logic [1:0] m_win;

    task automatic model_clear();
        for (int c = 0; c < 7; c++) heights[c] = 0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) board[r][c] = 2'b00;
        m_cnt = 0; m_row = 0; m_col = 0; m_over = 0; m_draw = 0; m_win = 0;
        exp_wr_q.delete(); exp_start_q.delete(); exp_res_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {7'd0, busy, wr_en, check_start, drop_done, drop_invalid, game_over, winner, draw,
                     move_row, move_col, row_read, col_read, wr_row, wr_col, wr_data}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; drop_req = 1'b0;
        #1;
        check_all_zero("reset_outputs");
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Issue one request, push its expected events, and wait for it to drain.
    task automatic drop(input int c, input logic [1:0] pl);
        int t, exp_busy, h;
        @(posedge clk); #1;
        t = cyc;
        busy_cyc = 0;
        drop_req = 1'b1; drop_col = 3'(c); player = pl;
        if (m_over || c >= 7 || pl == 2'b00 || pl == 2'b11) begin
            exp_res_q.push_back({16'(t + 1), 2'b10, m_row, m_col, m_over, m_win, m_draw});
            exp_busy = 1;
        end else if (heights[c] == 6) begin
            exp_res_q.push_back({16'(t + 7), 2'b10, m_row, m_col, m_over, m_win, m_draw});
            exp_busy = 7;
        end else begin
            h = heights[c];
            exp_wr_q.push_back({16'(t + 2 + h), 3'(h), 3'(c), pl});
            exp_start_q.push_back(16'(t + 3 + h));
            heights[c]++;
            m_row = 3'(h); m_col = 3'(c);
            if (m_cnt < 42) m_cnt++;
            if (winner_in != 2'b00) begin m_win = winner_in; m_over = 1; end
            else if (m_cnt == 42) begin m_draw = 1; m_over = 1; end
            exp_res_q.push_back({16'(t + 9 + h), 2'b01, m_row, m_col, m_over, m_win, m_draw});
            exp_busy = h + 8;
        end
        @(posedge clk); #1;
        drop_req = 1'b0;
        for (int i = 0; i < 100 && (busy || exp_res_q.size() != 0); i++) @(posedge clk);
        #1;
        if (exp_res_q.size() != 0 || exp_wr_q.size() != 0 || exp_start_q.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            exp_wr_q.delete(); exp_start_q.delete(); exp_res_q.delete();
        end
        check("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        model_clear();
        do_reset();

        // 1: empty board, P1 into col 3
        drop(3, 2'b01);
        // 2: col 2 gets rows 0-2, then P2 lands on row 3
        drop(2, 2'b01); drop(2, 2'b10); drop(2, 2'b01);
        drop(2, 2'b10);
        // 3: col 5 filled to the top, then one more drop is rejected
        for (int k = 0; k < 6; k++) drop(5, (k % 2 == 0) ? 2'b01 : 2'b10);
        drop(5, 2'b01);
        // 4: illegal column and illegal players
        drop(7, 2'b01);
        drop(0, 2'b11);
        drop(0, 2'b00);

        // 6: fill the whole board without a winner -> draw on the 42nd move
        do_reset();
        for (int c = 0; c < 7; c++)
            for (int k = 0; k < 6; k++) drop(c, (k % 2 == 0) ? 2'b01 : 2'b10);
        check("draw_flag", {30'd0, game_over, draw}, 32'd3);
        drop(1, 2'b01);

        // 5: checker reports P1 -> game over, further drops rejected
        do_reset();
        drop(4, 2'b10);
        winner_in = 2'b01;
        drop(4, 2'b01);
        check("winner_latched", {29'd0, game_over, winner}, 32'b101);
        winner_in = 2'b00;
        drop(3, 2'b10);

        // Reset during SCAN aborts the move and clears every output at once
        do_reset();
        drop(0, 2'b01); drop(0, 2'b10); drop(0, 2'b01);
        @(posedge clk); #1;
        drop_req = 1'b1; drop_col = 3'd0; player = 2'b10;
        @(posedge clk); #1;
        drop_req = 1'b0;
        @(posedge clk); #1;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_scan");
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("idle_after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
